// File: rtl/recon_writeback.sv
// recon_writeback: serialises one reconstructed block (MB_SIZE_L x MB_SIZE_W
// pixels) into the frame-buffer write port at raster addresses, one pixel per
// accepted write, in row-major order.
// Ports:
//   clk, reset     clock; synchronous active-low reset
//   in_valid/ready block handshake from the reconstructor
//   mbnumber       raster block index of the offered block
//   reconst        block pixels, index r*MB_SIZE_W + c
//   mem_we/addr/wdata/mem_ready  frame-buffer write port (valid/ready)
//   done           one-cycle pulse after the last write of a block is accepted
//   err            one-cycle pulse when a block with out-of-range index is rejected
module recon_writeback #(
  parameter int unsigned WIDTH     = 1280,
  parameter int unsigned LENGTH    = 720,
  parameter int unsigned MB_SIZE_L = 4,
  parameter int unsigned MB_SIZE_W = 4,
  parameter int unsigned ADDR_W    = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       mbnumber,
  input  logic [7:0]        reconst [MB_SIZE_L*MB_SIZE_W],
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  output logic              done,
  output logic              err
);

  localparam int unsigned MBS_PER_ROW = WIDTH / MB_SIZE_W;
  localparam int unsigned MB_TOTAL    = MBS_PER_ROW * (LENGTH / MB_SIZE_L);
  localparam int unsigned N           = MB_SIZE_L * MB_SIZE_W;
  localparam int unsigned RW          = (MB_SIZE_L > 1) ? $clog2(MB_SIZE_L) : 1;
  localparam int unsigned CW          = (MB_SIZE_W > 1) ? $clog2(MB_SIZE_W) : 1;
  localparam int unsigned IW          = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] row_off_q, row_off_d;
  logic [RW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        buf_q [N];
  logic              load_buf;
  logic [31:0]       mb_row, mb_col;
  logic [ADDR_W-1:0] base_calc;

  // Block origin in the frame; divisors are constants.
  always_comb begin
    mb_row    = mbnumber / MBS_PER_ROW;
    mb_col    = mbnumber % MBS_PER_ROW;
    base_calc = ADDR_W'(mb_row * MB_SIZE_L * WIDTH + mb_col * MB_SIZE_W);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    base_d      = base_q;
    row_off_d   = row_off_q;
    r_d         = r_q;
    c_d         = c_q;
    idx_d       = idx_q;
    load_buf    = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        mem_we_d   = 1'b0;
        if (in_valid && in_ready_q) begin
          if (mbnumber < MB_TOTAL) begin
            load_buf    = 1'b1;
            state_d     = WRITE;
            in_ready_d  = 1'b0;
            base_d      = base_calc;
            row_off_d   = '0;
            r_d         = '0;
            c_d         = '0;
            idx_d       = '0;
            mem_we_d    = 1'b1;
            mem_addr_d  = base_calc;
            mem_wdata_d = reconst[0];
          end else begin
            err_d = 1'b1;
          end
        end
      end

      WRITE: begin
        if (mem_ready) begin
          if (r_q == RW'(MB_SIZE_L - 1) && c_q == CW'(MB_SIZE_W - 1)) begin
            state_d  = DONE;
            mem_we_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            if (c_q == CW'(MB_SIZE_W - 1)) begin
              c_d       = '0;
              r_d       = r_q + RW'(1);
              row_off_d = row_off_q + ADDR_W'(WIDTH);
            end else begin
              c_d = c_q + CW'(1);
            end
            idx_d       = idx_q + IW'(1);
            mem_addr_d  = base_q + row_off_d + ADDR_W'(c_d);
            mem_wdata_d = buf_q[idx_d];
          end
        end
      end

      DONE: begin
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      base_q      <= '0;
      row_off_q   <= '0;
      r_q         <= '0;
      c_q         <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      base_q      <= base_d;
      row_off_q   <= row_off_d;
      r_q         <= r_d;
      c_q         <= c_d;
      idx_q       <= idx_d;
    end
  end

  // Pixel buffer keeps its contents across reset; loaded only on acceptance.
  always_ff @(posedge clk) begin
    if (reset && load_buf) begin
      buf_q <= reconst;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_recon_writeback.sv
module tb_recon_writeback;

  typedef struct packed {
    logic [19:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4x4 luma instance
  logic        a_in_valid, a_in_ready, a_we, a_mready, a_done, a_err;
  logic [31:0] a_mb;
  logic [7:0]  a_rec [16];
  logic [19:0] a_addr;
  logic [7:0]  a_wdata;

  // 8x8 chroma instance
  logic        b_in_valid, b_in_ready, b_we, b_mready, b_done, b_err;
  logic [31:0] b_mb;
  logic [7:0]  b_rec [64];
  logic [19:0] b_addr;
  logic [7:0]  b_wdata;

  recon_writeback #(.WIDTH(1280), .LENGTH(720), .MB_SIZE_L(4), .MB_SIZE_W(4), .ADDR_W(20)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .mbnumber(a_mb), .reconst(a_rec), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_ready(a_mready), .done(a_done), .err(a_err));

  recon_writeback #(.WIDTH(1280), .LENGTH(720), .MB_SIZE_L(8), .MB_SIZE_W(8), .ADDR_W(20)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mbnumber(b_mb), .reconst(b_rec), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_ready(b_mready), .done(b_done), .err(b_err));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int unsigned exp_base(input int unsigned mb, input int unsigned bs);
    return (mb / (1280 / bs)) * bs * 1280 + (mb % (1280 / bs)) * bs;
  endfunction

  // Scoreboards: expected writes and expected done cycles per instance.
  wr_t qa[$], qb[$];
  int  qda[$], qdb[$];
  int  a_wr_cnt, b_wr_cnt, a_err_cnt = 0;
  logic [19:0] a_first, a_last, b_first, b_last;
  wr_t ea, eb;
  logic        a_prev_stall = 1'b0;
  logic [19:0] a_prev_addr;
  logic [7:0]  a_prev_data;

  // Monitor for the 4x4 instance.
  always @(negedge clk) begin
    if (a_we === 1'b1 && a_mready) begin
      if (qa.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL a_unexpected_write: got addr %0d data %0d, expected no write", a_addr, a_wdata);
      end else begin
        ea = qa.pop_front();
        check("a_addr", 64'(a_addr), 64'(ea.addr));
        check("a_data", 64'(a_wdata), 64'(ea.data));
      end
      if (a_wr_cnt == 0) a_first = a_addr;
      a_last = a_addr;
      a_wr_cnt++;
    end
    if (a_prev_stall) begin
      check("a_hold_we", 64'(a_we), 64'(1));
      check("a_hold_addr", 64'(a_addr), 64'(a_prev_addr));
      check("a_hold_data", 64'(a_wdata), 64'(a_prev_data));
    end
    a_prev_stall = (a_we === 1'b1) && !a_mready;
    a_prev_addr  = a_addr;
    a_prev_data  = a_wdata;
    if (a_done === 1'b1) begin
      if (qda.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL a_unexpected_done: got pulse at cycle %0d, expected none", cyc);
      end else check("a_done_cycle", 64'(cyc), 64'(qda.pop_front()));
    end
    if (a_err === 1'b1) a_err_cnt++;
  end

  // Monitor for the 8x8 instance.
  always @(negedge clk) begin
    if (b_we === 1'b1 && b_mready) begin
      if (qb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL b_unexpected_write: got addr %0d data %0d, expected no write", b_addr, b_wdata);
      end else begin
        eb = qb.pop_front();
        check("b_addr", 64'(b_addr), 64'(eb.addr));
        check("b_data", 64'(b_wdata), 64'(eb.data));
      end
      if (b_wr_cnt == 0) b_first = b_addr;
      b_last = b_addr;
      b_wr_cnt++;
    end
    if (b_done === 1'b1) begin
      if (qdb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL b_unexpected_done: got pulse at cycle %0d, expected none", cyc);
      end else check("b_done_cycle", 64'(cyc), 64'(qdb.pop_front()));
    end
    if (b_err === 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL b_err: got err pulse, expected none");
    end
  end

  // Offer one block to the 4x4 instance; optionally stall the 6th write for 3 cycles.
  task automatic offer_a(input int unsigned mb, input int seed, input bit ok, input bit stall);
    int n, t0, err0;
    int unsigned base;
    err0     = a_err_cnt;
    a_wr_cnt = 0;
    @(posedge clk); #1;
    a_mb = mb;
    for (int i = 0; i < 16; i++) a_rec[i] = 8'(seed + i);
    a_in_valid = 1'b1;
    if (ok) begin
      base = exp_base(mb, 4);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          qa.push_back('{addr: 20'(base + r * 1280 + c), data: 8'(seed + r * 4 + c)});
    end
    n = 0;
    @(negedge clk);
    while (a_in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (a_in_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL a_accept_timeout: got in_ready %0b, expected 1", a_in_ready);
      a_in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    t0 = cyc;
    // Garbage after acceptance must not disturb the block; keep valid high while busy.
    a_mb = 32'hDEAD_BEEF;
    for (int i = 0; i < 16; i++) a_rec[i] = 8'hEE;
    if (!ok) a_in_valid = 1'b0;
    if (ok) qda.push_back(t0 + 16 + (stall ? 3 : 0));
    @(negedge clk);
    if (ok) begin
      check("a_busy_in_ready", 64'(a_in_ready), 64'(0));
      check("a_busy_err", 64'(a_err), 64'(0));
    end else begin
      check("a_rej_err", 64'(a_err), 64'(1));
      check("a_rej_in_ready", 64'(a_in_ready), 64'(1));
      @(negedge clk);
      check("a_rej_err_end", 64'(a_err), 64'(0));
      check("a_rej_in_ready2", 64'(a_in_ready), 64'(1));
      check("a_rej_err_count", 64'(a_err_cnt), 64'(err0 + 1));
      check("a_rej_no_write", 64'(a_wr_cnt), 64'(0));
      return;
    end
    if (stall) begin
      repeat (5) @(posedge clk);
      #1 a_mready = 1'b0;
      repeat (3) @(posedge clk);
      #1 a_mready = 1'b1;
    end
    n = 0;
    while (qda.size() != 0 && n < 200) begin @(negedge clk); #1; n++; end
    a_in_valid = 1'b0;
    check("a_drain", 64'(qda.size() + qa.size()), 64'(0));
    check("a_write_count", 64'(a_wr_cnt), 64'(16));
    check("a_err_count", 64'(a_err_cnt), 64'(err0));
    @(negedge clk);
    check("a_ready_back", 64'(a_in_ready), 64'(1));
  endtask

  // Offer one block to the 8x8 instance; abort > 0 pulls reset after that many writes.
  task automatic offer_b(input int unsigned mb, input int seed, input int abort);
    int n, t0, nexp;
    int unsigned base;
    b_wr_cnt = 0;
    nexp = (abort > 0) ? abort + 1 : 64;
    @(posedge clk); #1;
    b_mb = mb;
    for (int i = 0; i < 64; i++) b_rec[i] = 8'(seed + 3 * i);
    b_in_valid = 1'b1;
    base = exp_base(mb, 8);
    // On abort the write already on the port when reset is driven is still seen.
    for (int k = 0; k < nexp; k++)
      qb.push_back('{addr: 20'(base + (k / 8) * 1280 + (k % 8)), data: 8'(seed + 3 * k)});
    n = 0;
    @(negedge clk);
    while (b_in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (b_in_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL b_accept_timeout: got in_ready %0b, expected 1", b_in_ready);
      b_in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    t0 = cyc;
    b_in_valid = 1'b0;
    b_mb = 32'h0;
    for (int i = 0; i < 64; i++) b_rec[i] = 8'h55;
    if (abort > 0) begin
      repeat (abort) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("b_we_before_reset_sampled", 64'(b_we), 64'(1));
      @(negedge clk);
      check("b_we_after_reset", 64'(b_we), 64'(0));
      check("b_ready_in_reset", 64'(b_in_ready), 64'(0));
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("b_ready_after_release", 64'(b_in_ready), 64'(1));
      check("a_ready_after_release", 64'(a_in_ready), 64'(1));
      repeat (70) @(negedge clk);
      check("b_abort_writes", 64'(b_wr_cnt), 64'(nexp));
      check("b_abort_queue", 64'(qb.size()), 64'(0));
      return;
    end
    qdb.push_back(t0 + 64);
    n = 0;
    while (qdb.size() != 0 && n < 300) begin @(negedge clk); #1; n++; end
    check("b_drain", 64'(qdb.size() + qb.size()), 64'(0));
    check("b_write_count", 64'(b_wr_cnt), 64'(64));
    @(negedge clk);
    check("b_ready_back", 64'(b_in_ready), 64'(1));
  endtask

  initial begin
    reset = 1'b0;
    a_in_valid = 1'b0; a_mb = '0; a_mready = 1'b1;
    b_in_valid = 1'b0; b_mb = '0; b_mready = 1'b1;
    for (int i = 0; i < 16; i++) a_rec[i] = '0;
    for (int i = 0; i < 64; i++) b_rec[i] = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(a_in_ready), 64'(0));
    check("rst_we", 64'(a_we), 64'(0));
    check("rst_done", 64'(a_done), 64'(0));
    check("rst_err", 64'(a_err), 64'(0));
    check("rst_addr", 64'(a_addr), 64'(0));
    check("rst_wdata", 64'(a_wdata), 64'(0));
    check("rst_b_in_ready", 64'(b_in_ready), 64'(0));
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready_lag", 64'(a_in_ready), 64'(0));
    @(negedge clk);
    check("rel_in_ready", 64'(a_in_ready), 64'(1));

    // Top-left block, data 10..25
    offer_a(0, 10, 1'b1, 1'b0);
    check("blk0_first", 64'(a_first), 64'(0));
    check("blk0_last", 64'(a_last), 64'(3843));

    // Interior block
    offer_a(321, 40, 1'b1, 1'b0);
    check("blk321_first", 64'(a_first), 64'(5124));
    check("blk321_last", 64'(a_last), 64'(8967));

    // Last block of the 1280x720 frame with 4x4 blocks
    offer_a(57599, 100, 1'b1, 1'b0);
    check("last_first", 64'(a_first), 64'(917756));
    check("last_last", 64'(a_last), 64'(921599));

    // Out-of-range indices
    offer_a(57600, 0, 1'b0, 1'b0);
    offer_a(230400, 0, 1'b0, 1'b0);

    // Backpressure on the 6th write
    offer_a(5, 200, 1'b1, 1'b1);
    check("bp_first", 64'(a_first), 64'(20));
    check("bp_last", 64'(a_last), 64'(3863));

    // 8x8 block aborted by reset after 20 writes, then a normal block
    offer_b(161, 1, 20);
    check("b161_first", 64'(b_first), 64'(10248));
    offer_b(14399, 7, 0);
    check("b_last_first", 64'(b_first), 64'(912632));
    check("b_last_last", 64'(b_last), 64'(921599));

    repeat (3) @(negedge clk);
    check("a_queues_empty", 64'(qa.size() + qda.size()), 64'(0));
    check("b_queues_empty", 64'(qb.size() + qdb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
